// File: rtl/tff_toggle_sched_if.sv
// rtl/tff_toggle_sched_if.sv - request/status bundle between requesters and the TFF toggle scheduler
interface tff_toggle_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*CNT_W-1:0] req_count;
  logic [NUM_CH-1:0]       req_ready;
  logic                    abort;
  logic [NUM_CH-1:0]       tff_en;
  logic [NUM_CH-1:0]       tff_q;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  // Requester side: raises requests and abort, observes the bank.
  modport master (
    output req_valid, req_count, abort,
    input  req_ready, tff_en, tff_q, busy, done
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_count, abort,
    output req_ready, tff_en, tff_q, busy, done
  );
endinterface

// File: rtl/tff_toggle_sched.sv
// rtl/tff_toggle_sched.sv - round-robin toggle scheduler owning a bank of toggle flip-flops
module tff_toggle_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  tff_toggle_sched_if.slave bus
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_t;

  ch_state_t            state_q [NUM_CH];
  ch_state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]     rem_q   [NUM_CH];
  logic [CNT_W-1:0]     rem_d   [NUM_CH];
  logic [PTR_W-1:0]     rr_q;
  logic [PTR_W-1:0]     rr_d;
  logic [NUM_CH-1:0]    en_q;
  logic [NUM_CH-1:0]    en_d;
  logic [NUM_CH-1:0]    done_q;
  logic [NUM_CH-1:0]    done_d;
  logic [NUM_CH-1:0]    q_q;

  logic [NUM_CH-1:0]    active;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    ready;
  logic [NUM_CH-1:0]    accept;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;

  // Channel status: a channel stays busy until its last toggle has reached the bank.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state_q[i] == CH_ACTIVE);
    end
    busy   = active | en_q;
    ready  = ~busy & {NUM_CH{~bus.abort}};
    accept = bus.req_valid & ready;
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = PTR_W'((int'(rr_q) + k) % NUM_CH);
      if (!grant_valid && active[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state: abort wins, otherwise retire one grant and load any accepted requests.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rr_d    = rr_q;
    en_d    = '0;
    done_d  = '0;
    if (bus.abort) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_d[i] = CH_IDLE;
        rem_d[i]   = '0;
      end
    end else begin
      if (grant_valid) begin
        en_d[grant_idx]  = 1'b1;
        rr_d             = grant_idx;
        rem_d[grant_idx] = rem_q[grant_idx] - CNT_W'(1);
        // Last toggle: done is registered alongside its tff_en bit.
        if (rem_q[grant_idx] == CNT_W'(1)) begin
          state_d[grant_idx] = CH_IDLE;
          done_d[grant_idx]  = 1'b1;
        end
      end
      // An accepting channel is never the granted one: accept needs it not busy.
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          rem_d[i] = bus.req_count[i*CNT_W +: CNT_W];
          if (bus.req_count[i*CNT_W +: CNT_W] == '0) begin
            done_d[i] = 1'b1;
          end else begin
            state_d[i] = CH_ACTIVE;
          end
        end
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_IDLE;
        rem_q[i]   <= '0;
      end
      rr_q   <= PTR_W'(NUM_CH - 1);
      en_q   <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // The TFF bank: an enable already issued is applied even on an abort edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_q ^ en_q;
    end
  end

  assign bus.req_ready = ready;
  assign bus.tff_en    = en_q;
  assign bus.tff_q     = q_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;

  a_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en_q));

endmodule

// File: doc/tff_toggle_sched.md
# tff_toggle_sched

Round-robin scheduler that owns a bank of NUM_CH toggle flip-flops and issues their toggle enables on behalf of per-channel requesters. Each channel asks for a number of toggles through a valid/ready handshake. The block grants at most one toggle per clock across the whole bank, which bounds simultaneous switching, and signals completion per channel. It sits between software- or FSM-driven requesters and the divider/phase TFF bank, and it contains the bank itself.

## Interface
- NUM_CH, 4: number of channels / TFFs (2..16)
- CNT_W, 8: width of a toggle-count request
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_CH  per-channel request valid
- req_count  in  NUM_CH*CNT_W  toggles requested; channel i at bits [i*CNT_W +: CNT_W]
- req_ready  out  NUM_CH  channel can accept a request
- abort  in  1  synchronous cancel of all outstanding work
- tff_en  out  NUM_CH  registered toggle enable, at most one bit set
- tff_q  out  NUM_CH  TFF outputs, registered
- busy  out  NUM_CH  channel has work or an issued-but-unapplied toggle
- done  out  NUM_CH  one-cycle pulse when a channel's request completes

## Operation
- Cycle n is the interval between edge n and edge n+1.
- Reset values: tff_q=0, tff_en=0, done=0, busy=0, remaining=0, all channels IDLE, rr_ptr=NUM_CH-1. req_ready=all-ones, because it is combinational.
- Per-channel state is IDLE or ACTIVE, plus remaining[CNT_W-1:0].
- busy[i] = ACTIVE[i] | tff_en[i].
- req_ready[i] = ~busy[i] & ~abort.
- Accept: when req_valid[i] & req_ready[i] at an edge, load remaining=req_count[i].
  - If req_count is nonzero, the channel goes ACTIVE.
  - If req_count==0, the channel stays IDLE, done[i] pulses the next cycle, and no toggle is issued.
- Arbitration runs each cycle among ACTIVE channels, with abort low.
  - Search order is rr_ptr+1, rr_ptr+2, …, modulo NUM_CH.
  - The first ACTIVE channel found is granted.
  - At the next edge, rr_ptr takes the granted index and remaining of that channel decrements.
- tff_en is the registered grant, so tff_en[g] is high during the cycle after the grant.
- TFF update: tff_q[i] <= tff_q[i] ^ tff_en[i] every edge. This is the only way tff_q changes outside reset.
- Final grant (remaining==1): the channel returns to IDLE at that edge. done[i] is registered together with the final tff_en[i], so both are high in the same cycle.
- Abort, sampled high at an edge:
  - All channels go IDLE, remaining=0, tff_en=0.
  - No done pulses. tff_q and rr_ptr are retained.
  - A toggle already in tff_en during the abort cycle is still applied at that edge.
- Abort has priority over accept. req_ready is low while abort is high.
- A channel cannot be re-armed while busy. A request held valid during completion is accepted in the first cycle busy is low.

## Timing
- Single channel, count N, no contention:
  - Accept in cycle 0.
  - ACTIVE from cycle 1; grants in cycles 1..N.
  - tff_en high in cycles 2..N+1; tff_q toggles at edges 3..N+2.
  - done in cycle N+1; req_ready high again in cycle N+2.
- K channels ACTIVE: each gets exactly one grant per K cycles. Grants rotate strictly, with no channel starving.
- The bank's toggle rate is at most one per cycle.

## Test plan
- Reset mid-operation:
  - Stimulus: ch0 count 5; assert rst_n low after 2 toggles.
  - Required: tff_q=0, tff_en=0, busy=0, req_ready=all-ones immediately (asynchronous); no done.
- Single request:
  - Stimulus: ch2 count 3 accepted in cycle 0.
  - Required: tff_en=4'b0100 in cycles 2,3,4; tff_q[2] reads 1,0,1 after edges 3,4,5; done[2] in cycle 4; req_ready[2] high in cycle 5.
- Contention:
  - Stimulus: ch0 count 2, ch1 count 2 and ch3 count 1, all accepted in cycle 0.
  - Required: grant order 0,1,3,0,1 in cycles 1..5; done[3] in cycle 4; done[0] in cycle 5; done[1] in cycle 6; tff_en one-hot or zero throughout.
- Zero count:
  - Stimulus: ch1 count 0.
  - Required: done[1] next cycle; tff_en never set; tff_q[1] unchanged.
- Abort:
  - Stimulus: ch0 count 200 accepted; abort in cycle 10.
  - Required: tff_en=0 from cycle 11; busy=0 and req_ready=1 from cycle 11; no done; tff_q[0] retains its value after edge 11.
- Back-to-back:
  - Stimulus: req_valid[0] held high with count 1.
  - Required: accepts repeat every 3 cycles; tff_q[0] toggles once per accept.
